// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and a parity helper
// used by both the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_COMMIT    = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int MAX_DATA_BITS = 9;

    // Parity bit that belongs on the wire for the low nbits of data.
    // The result is meaningless for PAR_NONE; callers must not use it then.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int nbits,
                                        input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < nbits) begin
                p = p ^ data[i];
            end
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the RX pin followed by a 3-deep history register
// whose 2-of-3 majority is the filtered bit value used by the receiver FSM.
module uart_rx_sampler (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_serial_data,
    output logic line,
    output logic majority
);

    logic       sync_1;
    logic       sync_2;
    logic [2:0] hist;

    // Everything resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            hist   <= 3'b111;
        end else begin
            sync_1 <= i_serial_data;
            sync_2 <= sync_1;
            hist   <= {hist[1:0], sync_2};
        end
    end

    assign line     = sync_2;
    assign majority = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: majority-voted sampling, parity/framing/break/overrun
// detection, and a valid/ready output register for a byte-stream consumer.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_serial_data,
    input  logic                 i_ready,
    output logic                 o_dv,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun,
    output state_t               o_state
);

    // Handshake: a frame is transferred in every cycle where o_dv & i_ready;
    // o_dv and its data/flags stay stable until that cycle and o_dv drops at the
    // following edge unless a new frame is committed in the same cycle.

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLK_PER_BIT / 2 + 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (CLK_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_frame: illegal parameter combination");
    end

    logic line;
    logic maj;

    uart_rx_sampler u_sampler (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_serial_data (i_serial_data),
        .line          (line),
        .majority      (maj)
    );

    state_t               state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_bit_n;
    logic                 frame_err, frame_err_n;
    logic                 saw_one, saw_one_n;
    logic                 bit_tick;

    assign bit_tick = (clk_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            frame_err <= 1'b0;
            saw_one   <= 1'b0;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            par_bit   <= par_bit_n;
            frame_err <= frame_err_n;
            saw_one   <= saw_one_n;
        end
    end

    always_comb begin
        state_n     = state;
        clk_cnt_n   = clk_cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        par_bit_n   = par_bit;
        frame_err_n = frame_err;
        saw_one_n   = saw_one;

        case (state)
            ST_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (!line) begin
                    state_n = ST_START;
                end
            end

            // A start bit that is high again at mid-bit was a glitch.
            ST_START: begin
                clk_cnt_n = clk_cnt + 1'b1;
                if (clk_cnt == CNT_MID) begin
                    clk_cnt_n = '0;
                    if (maj) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n     = ST_DATA;
                        bit_cnt_n   = '0;
                        par_bit_n   = 1'b0;
                        frame_err_n = 1'b0;
                        saw_one_n   = 1'b0;
                    end
                end
            end

            // LSB arrives first, so shifting in at the top leaves it at bit 0.
            ST_DATA: begin
                clk_cnt_n = clk_cnt + 1'b1;
                if (bit_tick) begin
                    clk_cnt_n = '0;
                    shreg_n   = {maj, shreg[DATA_BITS-1:1]};
                    saw_one_n = saw_one | maj;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                clk_cnt_n = clk_cnt + 1'b1;
                if (bit_tick) begin
                    clk_cnt_n = '0;
                    par_bit_n = maj;
                    saw_one_n = saw_one | maj;
                    state_n   = ST_STOP;
                end
            end

            ST_STOP: begin
                clk_cnt_n = clk_cnt + 1'b1;
                if (bit_tick) begin
                    clk_cnt_n = '0;
                    saw_one_n = saw_one | maj;
                    if (!maj) begin
                        frame_err_n = 1'b1;
                    end
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = ST_COMMIT;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            // A low stop bit (e.g. a break) must see the line high again before rearming.
            ST_COMMIT: begin
                clk_cnt_n = '0;
                state_n   = frame_err ? ST_WAIT_HIGH : ST_IDLE;
            end

            ST_WAIT_HIGH: begin
                if (line) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    logic [MAX_DATA_BITS-1:0] data_ext;
    logic                     par_err_calc;

    always_comb begin
        data_ext                = '0;
        data_ext[DATA_BITS-1:0] = shreg;
        par_err_calc            = 1'b0;
        if (PARITY != PAR_NONE) begin
            par_err_calc = (parity_bit(data_ext, DATA_BITS, PARITY) != par_bit);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dv         <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (state == ST_COMMIT) begin
                if (!o_dv || i_ready) begin
                    o_dv         <= 1'b1;
                    o_rx_data    <= shreg;
                    o_parity_err <= par_err_calc;
                    o_frame_err  <= frame_err;
                    o_break      <= ~saw_one;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_dv && i_ready) begin
                o_dv <= 1'b0;
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three configurations (8E1, 8O1, 8N2) share one
// clock and reset; accepted frames are checked against a queue of expected frames.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int W   = 13;  // {inst[1:0], data[7:0], parity_err, frame_err, break}

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [2:0] ser   = 3'b111;
    logic [2:0] rdy   = 3'b111;
    logic [2:0] dv;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] brk;
    logic [2:0] ovr;
    logic [7:0] rxd [3];
    state_t     st  [3];

    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    int checks     = 0;
    int failures   = 0;
    int mon_checks = 0;
    int mon_fails  = 0;
    int dv_cnt  [3] = '{0, 0, 0};
    int ovr_cnt [3] = '{0, 0, 0};

    always #5 i_clk = ~i_clk;

    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_even (
        .i_clk(i_clk), .i_rst(i_rst), .i_serial_data(ser[0]), .i_ready(rdy[0]),
        .o_dv(dv[0]), .o_rx_data(rxd[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
        .o_break(brk[0]), .o_overrun(ovr[0]), .o_state(st[0])
    );

    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) dut_odd (
        .i_clk(i_clk), .i_rst(i_rst), .i_serial_data(ser[1]), .i_ready(rdy[1]),
        .o_dv(dv[1]), .o_rx_data(rxd[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
        .o_break(brk[1]), .o_overrun(ovr[1]), .o_state(st[1])
    );

    uart_rx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_n2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_serial_data(ser[2]), .i_ready(rdy[2]),
        .o_dv(dv[2]), .o_rx_data(rxd[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
        .o_break(brk[2]), .o_overrun(ovr[2]), .o_state(st[2])
    );

    // Scoreboard side: every accepted frame is popped and compared.
    always @(negedge i_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv[k]) dv_cnt[k]++;
            if (ovr[k]) ovr_cnt[k]++;
            if (dv[k] && rdy[k]) begin
                mon_got = {2'(k), rxd[k], perr[k], ferr[k], brk[k]};
                mon_checks++;
                if (exp_q.size() == 0) begin
                    mon_fails++;
                    $error("FAIL unexpected_frame inst=%0d got=%h required=none", k, mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    assert (mon_got === mon_exp) else begin
                        mon_fails++;
                        $error("FAIL frame inst=%0d got=%h required=%h", k, mon_got, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] req);
        checks++;
        assert (got === req) else begin
            failures++;
            $error("FAIL %s got=%0h required=%0h", tag, got, req);
        end
    endtask

    // One bit period; a glitch flips the line for one cycle near mid-bit.
    task automatic drive_bit(input int k, input logic v, input bit glitch);
        ser[k] = v;
        if (glitch) begin
            tick(9);
            ser[k] = ~v;
            tick(1);
            ser[k] = v;
            tick(CPB - 10);
        end else begin
            tick(CPB);
        end
    endtask

    // Drives one frame and, if push is set, queues the frame the receiver should deliver.
    task automatic frame(input int k, input logic [7:0] d, input int mode, input logic pbit,
                         input logic s1, input logic s2, input int nstop, input int glitch_bit,
                         input bit push);
        int   ones;
        logic pe;
        logic fe;
        logic bk;
        ones = $countones(d) + int'(pbit);
        pe   = 1'b0;
        if (mode == PAR_ODD)  pe = (ones % 2 == 0);
        if (mode == PAR_EVEN) pe = (ones % 2 == 1);
        fe = !s1 || (nstop == 2 && !s2);
        bk = (d == 8'h00) && (mode == PAR_NONE || !pbit) && !s1 && (nstop == 1 || !s2);
        if (push) exp_q.push_back({2'(k), d, pe, fe, bk});
        drive_bit(k, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(k, d[i], i == glitch_bit);
        if (mode != PAR_NONE) drive_bit(k, pbit, 1'b0);
        drive_bit(k, s1, 1'b0);
        if (nstop == 2) drive_bit(k, s2, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            tick(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int obase;
        logic [7:0] r;
        logic       rp;

        // Reset state
        tick(3);
        for (int k = 0; k < 3; k++) begin
            check("rst_dv", dv[k], 0);
            check("rst_data", rxd[k], 0);
            check("rst_state", st[k], ST_IDLE);
        end
        check("rst_flags", {perr, ferr, brk, ovr}, 0);
        i_rst = 1'b0;
        tick(CPB);

        // 8E1 clean frame, single-cycle o_dv pulse
        base = dv_cnt[0];
        frame(0, 8'hA5, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
        drain("even_a5");
        check("even_a5_pulse", dv_cnt[0] - base, 1);
        frame(0, 8'h01, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1, -1, 1'b1);
        frame(0, 8'h01, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
        drain("even_01");
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom_range(0, 255));
            frame(0, r, PAR_EVEN, ^r, 1'b1, 1'b1, 1, -1, 1'b1);
        end
        drain("even_rand");

        // 8O1 parity
        frame(1, 8'h3C, PAR_ODD, 1'b1, 1'b1, 1'b1, 1, -1, 1'b1);
        frame(1, 8'h3C, PAR_ODD, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
        frame(1, 8'h3D, PAR_ODD, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            r  = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            frame(1, r, PAR_ODD, rp, 1'b1, 1'b1, 1, -1, 1'b1);
        end
        drain("odd");

        // 8N2 second stop low, then a long low line must not retrigger
        base = dv_cnt[2];
        frame(2, 8'h55, PAR_NONE, 1'b0, 1'b1, 1'b0, 2, -1, 1'b1);
        drain("n2_frame_err");
        tick(40 * CPB);
        check("n2_hold_dv", dv_cnt[2] - base, 1);
        check("n2_wait_high", st[2], ST_WAIT_HIGH);
        ser[2] = 1'b1;
        tick(2 * CPB);
        check("n2_idle", st[2], ST_IDLE);
        frame(2, 8'h12, PAR_NONE, 1'b0, 1'b1, 1'b1, 2, -1, 1'b1);
        drain("n2_recover");

        // Break on 8E1
        frame(0, 8'h00, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1, -1, 1'b1);
        drain("break");
        tick(19 * CPB);
        check("break_wait_high", st[0], ST_WAIT_HIGH);
        ser[0] = 1'b1;
        tick(8);
        check("break_idle", st[0], ST_IDLE);
        tick(CPB);

        // Short low glitch on idle, then a one-cycle high glitch inside data bit 3
        base = dv_cnt[0];
        ser[0] = 1'b0;
        tick(3);
        ser[0] = 1'b1;
        tick(3 * CPB);
        check("glitch_no_dv", dv_cnt[0] - base, 0);
        check("glitch_idle", st[0], ST_IDLE);
        frame(0, 8'h00, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1, 3, 1'b1);
        drain("glitch_data");

        // Overrun: consumer stalled across two back-to-back frames
        rdy[0] = 1'b0;
        obase = ovr_cnt[0];
        frame(0, 8'h11, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
        frame(0, 8'h22, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1, -1, 1'b0);
        check("ovr_dv_held", dv[0], 1);
        check("ovr_data_kept", rxd[0], 8'h11);
        check("ovr_pulse", ovr_cnt[0] - obase, 1);
        rdy[0] = 1'b1;
        drain("ovr_accept");
        tick(1);
        check("ovr_dv_fall", dv[0], 0);

        // Reset mid-frame while a frame is held
        rdy[0] = 1'b0;
        frame(0, 8'h44, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1, -1, 1'b0);
        check("held_dv", dv[0], 1);
        ser[0] = 1'b0;
        tick(3 * CPB);
        i_rst = 1'b1;
        #1;
        check("midrst_dv", dv[0], 0);
        check("midrst_data", rxd[0], 0);
        check("midrst_state", st[0], ST_IDLE);
        ser[0] = 1'b1;
        tick(2);
        i_rst  = 1'b0;
        rdy[0] = 1'b1;
        tick(2 * CPB);
        check("post_rst_state", st[0], ST_IDLE);
        check("post_rst_dv", dv[0], 0);
        check("queue_empty", exp_q.size(), 0);

        checks   = checks + mon_checks;
        failures = failures + mon_fails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
